// File: rtl/uart_reg_pkg.sv
// Shared constants and helpers for the UART register bank.
// Optional shadow/commit behaviour in the top is enabled by UART_REG_BANK_SHADOW_EN.
package uart_reg_pkg;

  localparam int REG_ADDR_W = 4;
  localparam int REG_NUM    = 16;
  localparam int REG_DATA_W = 8;

  // Writing this address commits the shadow array when shadowing is built in
  localparam logic [REG_ADDR_W-1:0] COMMIT_ADDR = 4'hF;

  // Lowest bit of register idx inside the flattened reg_image bus
  function automatic int reg_lsb(input int idx);
    return idx * REG_DATA_W;
  endfunction

endpackage

// File: rtl/uart_reg_bank_rise_detect.sv
// Level-to-pulse converter: registers the input and flags a 0->1 transition.
// INIT_VAL sets the history bit at reset; 1 suppresses a pulse when the
// input is already high as reset is released.
module rise_detect #(
  parameter logic INIT_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic pulse
);

  logic din_q;

  // Previous-cycle copy of the input
  always_ff @(posedge clk) begin
    if (reset) din_q <= INIT_VAL;
    else       din_q <= din;
  end

  assign pulse = din & ~din_q;

endmodule

// File: rtl/uart_reg_bank.sv
// Write-only register bank fed by the UART pair decoder. Each new rising
// edge of uart_ready performs one write, pulses the matching strobe for one
// clock and bumps a wrapping debug counter.
// Define UART_REG_BANK_SHADOW_EN to stage writes to 0..14 in a shadow array
// and apply them all at once when COMMIT_ADDR is written.
module uart_reg_bank
  import uart_reg_pkg::*;
#(
  parameter int             ADDR_W    = REG_ADDR_W,
  parameter int             NUM_REGS  = 2 ** ADDR_W,
  parameter logic [7:0]     RESET_VAL = 8'h00
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [ADDR_W-1:0]         uart_addr,
  input  logic [7:0]                uart_data,
  input  logic                      uart_ready,
  output logic [NUM_REGS*8-1:0]     reg_image,
  output logic [NUM_REGS-1:0]       reg_wstb,
  output logic [7:0]                write_count
);

  localparam logic [NUM_REGS-1:0] ONE = {{(NUM_REGS-1){1'b0}}, 1'b1};

  logic                wr_evt;
  logic [7:0]          regs_reg [NUM_REGS];
  logic [NUM_REGS-1:0] wstb_reg;
  logic [7:0]          count_reg;

  // History resets high so a ready level held through reset is not a write
  rise_detect #(
    .INIT_VAL (1'b1)
  ) u_rise (
    .clk   (clk),
    .reset (reset),
    .din   (uart_ready),
    .pulse (wr_evt)
  );

`ifdef UART_REG_BANK_SHADOW_EN
  logic [7:0] shadow_reg [NUM_REGS];

  // Staged writes; commit copies shadow into live regs and strobes every register
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_reg[i]   <= RESET_VAL;
        shadow_reg[i] <= RESET_VAL;
      end
      wstb_reg  <= '0;
      count_reg <= 8'h00;
    end else begin
      wstb_reg <= '0;
      if (wr_evt) begin
        count_reg <= count_reg + 8'd1;
        if (uart_addr == COMMIT_ADDR) begin
          for (int i = 0; i < NUM_REGS - 1; i++) begin
            regs_reg[i] <= shadow_reg[i];
          end
          regs_reg[NUM_REGS-1]   <= uart_data;
          shadow_reg[NUM_REGS-1] <= uart_data;
          wstb_reg               <= '1;
        end else begin
          shadow_reg[uart_addr] <= uart_data;
        end
      end
    end
  end
`else
  // Direct write of the addressed register with a one-hot, one-clock strobe
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_reg[i] <= RESET_VAL;
      end
      wstb_reg  <= '0;
      count_reg <= 8'h00;
    end else begin
      wstb_reg <= '0;
      if (wr_evt) begin
        regs_reg[uart_addr] <= uart_data;
        wstb_reg            <= ONE << uart_addr;
        count_reg           <= count_reg + 8'd1;
      end
    end
  end
`endif

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_image
    assign reg_image[reg_lsb(gi) +: REG_DATA_W] = regs_reg[gi];
  end

  assign reg_wstb    = wstb_reg;
  assign write_count = count_reg;

endmodule

// File: tb/tb_uart_reg_bank.sv
// Scoreboard bench for uart_reg_bank: stimulus pushes the expected strobe
// response into a queue, a negedge monitor pops and compares whenever the
// DUT shows a write strobe. Direct checks cover no-strobe phases.
module tb_uart_reg_bank;

  typedef struct packed {
    logic [127:0] img;
    logic [15:0]  wstb;
    logic [7:0]   cnt;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   uart_addr;
  logic [7:0]   uart_data;
  logic         uart_ready;
  logic [127:0] reg_image;
  logic [15:0]  reg_wstb;
  logic [7:0]   write_count;

  int   checks = 0;
  int   failures = 0;
  int   strobe_cnt = 0;
  int   exp_strobes = 0;
  bit   done = 1'b0;
  exp_t exp_q[$];

  logic [7:0] exp_regs   [16];
  logic [7:0] exp_shadow [16];
  logic [7:0] exp_count;

  uart_reg_bank dut (
    .clk         (clk),
    .reset       (reset),
    .uart_addr   (uart_addr),
    .uart_data   (uart_data),
    .uart_ready  (uart_ready),
    .reg_image   (reg_image),
    .reg_wstb    (reg_wstb),
    .write_count (write_count)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end else begin
      $display("ok   %s val=%h", name, act);
    end
  endtask

  function automatic logic [127:0] model_image();
    logic [127:0] v;
    for (int i = 0; i < 16; i++) v[i*8 +: 8] = exp_regs[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      exp_regs[i]   = 8'h00;
      exp_shadow[i] = 8'h00;
    end
    exp_count = 8'h00;
  endtask

  // Update the model for one accepted write and queue any strobe it produces
  task automatic do_rise(input logic [3:0] a, input logic [7:0] d);
    exp_t e;
    exp_count = exp_count + 8'd1;
`ifdef UART_REG_BANK_SHADOW_EN
    if (a == 4'hF) begin
      for (int i = 0; i < 15; i++) exp_regs[i] = exp_shadow[i];
      exp_regs[15]   = d;
      exp_shadow[15] = d;
      e.img  = model_image();
      e.wstb = 16'hFFFF;
      e.cnt  = exp_count;
      exp_q.push_back(e);
      exp_strobes++;
    end else begin
      exp_shadow[a] = d;
    end
`else
    exp_regs[a] = d;
    e.img  = model_image();
    e.wstb = 16'h0001 << a;
    e.cnt  = exp_count;
    exp_q.push_back(e);
    exp_strobes++;
`endif
    uart_addr  = a;
    uart_data  = d;
    uart_ready = 1'b1;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [7:0] d);
    do_rise(a, d);
    @(posedge clk); #1;
    uart_ready = 1'b0;
    @(posedge clk); #1;
  endtask

  // Monitor: every strobe must match the oldest queued expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!done && reg_wstb !== 16'h0000) begin
        strobe_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_strobe", {112'h0, reg_wstb}, 128'h0);
        end else begin
          e = exp_q.pop_front();
          $display("txn  wstb=%h cnt=%h", reg_wstb, write_count);
          chk("sb_wstb", {112'h0, reg_wstb}, {112'h0, e.wstb});
          chk("sb_image", reg_image, e.img);
          chk("sb_count", {120'h0, write_count}, {120'h0, e.cnt});
        end
      end
    end
  end

  initial begin
    model_reset();
    reset      = 1'b1;
    uart_ready = 1'b1;
    uart_addr  = 4'h0;
    uart_data  = 8'h00;

    // Reset held with ready high, then ready stays high: no write
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wstb", {112'h0, reg_wstb}, 128'h0);
    chk("rst_count", {120'h0, write_count}, 128'h0);
    chk("rst_image", reg_image, 128'h0);
    reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("held_count", {120'h0, write_count}, 128'h0);
    chk("held_image", reg_image, 128'h0);
    uart_ready = 1'b0;
    @(posedge clk); #1;

    // Single write, then level-held ready with changed data: no repeat
    do_rise(4'h3, 8'hA5);
    @(posedge clk); #1;
    uart_addr = 4'h3;
    uart_data = 8'h5A;
    repeat (20) @(posedge clk);
    #1;
    chk("hold_reg3", {120'h0, reg_image[31:24]}, {120'h0, exp_regs[3]});
    chk("hold_count", {120'h0, write_count}, {120'h0, exp_count});
    uart_ready = 1'b0;
    @(posedge clk); #1;

    // Clean reset, then 256 writes cycling through all addresses
    reset = 1'b1;
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    begin
      int s0, e0;
      s0 = strobe_cnt;
      e0 = exp_strobes;
      for (int i = 0; i < 256; i++) begin
        do_write(4'(i % 16), 8'(i * 7 + 3));
      end
      @(posedge clk); #1;
      chk("loop_strobes", 128'(strobe_cnt - s0), 128'(exp_strobes - e0));
    end
    chk("loop_count", {120'h0, write_count}, {120'h0, exp_count});
    chk("loop_image", reg_image, model_image());

    // Reset coincident with the ready rise: write lost, no spurious write after
    @(posedge clk); #1;
    uart_addr  = 4'h7;
    uart_data  = 8'h11;
    uart_ready = 1'b1;
    reset      = 1'b1;
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("race_reg7", {120'h0, reg_image[63:56]}, 128'h0);
    chk("race_count", {120'h0, write_count}, 128'h0);
    uart_ready = 1'b0;
    @(posedge clk); #1;
    do_write(4'h7, 8'h11);
    chk("after_race_image", reg_image, model_image());
    chk("after_race_count", {120'h0, write_count}, {120'h0, exp_count});

`ifdef UART_REG_BANK_SHADOW_EN
    // Shadow staging then commit
    begin
      logic [127:0] before;
      before = reg_image;
      do_write(4'h1, 8'h22);
      do_write(4'h2, 8'h33);
      chk("shadow_live_unchanged", reg_image, before);
      do_write(4'hF, 8'h44);
      chk("commit_reg1", {120'h0, reg_image[15:8]}, {120'h0, 8'h22});
      chk("commit_reg2", {120'h0, reg_image[23:16]}, {120'h0, 8'h33});
      chk("commit_reg15", {120'h0, reg_image[127:120]}, {120'h0, 8'h44});
    end
`endif

    repeat (2) @(posedge clk);
    #1;
    done = 1'b1;
    chk("queue_drained", 128'(exp_q.size()), 128'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
